// File: rtl/rv32_alu_share_arb_if.sv
// Request / ALU / response bundle for rv32_alu_share_arb.
// Signal suffixes are from the arbiter's point of view: the slave modport is
// the arbiter, the master modport is the surrounding issue/ALU logic.
// ALU operation encoding (4 bits): ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5
// SRL=6 SRA=7 OR=8 AND=9.
interface rv32_alu_share_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
);
    // Request side
    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic [NUM_REQ-1:0][31:0]       req_op1_i;
    logic [NUM_REQ-1:0][31:0]       req_op2_i;
    logic [NUM_REQ-1:0][3:0]        req_opsel_i;
    logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag_i;

    // Shared ALU side
    logic [31:0]                    alu_op1_o;
    logic [31:0]                    alu_op2_o;
    logic [3:0]                     alu_opsel_o;
    logic [31:0]                    alu_result_i;

    // Response side
    logic [NUM_REQ-1:0]             rsp_valid_o;
    logic [NUM_REQ-1:0]             rsp_ready_i;
    logic [NUM_REQ-1:0][31:0]       rsp_result_o;
    logic [NUM_REQ-1:0][TAG_W-1:0]  rsp_tag_o;

    // Utilisation counter
    logic [31:0]                    busy_cycles_o;

    modport slave (
        input  req_valid_i, req_op1_i, req_op2_i, req_opsel_i, req_tag_i,
        input  alu_result_i, rsp_ready_i,
        output req_ready_o, alu_op1_o, alu_op2_o, alu_opsel_o,
        output rsp_valid_o, rsp_result_o, rsp_tag_o, busy_cycles_o
    );

    modport master (
        output req_valid_i, req_op1_i, req_op2_i, req_opsel_i, req_tag_i,
        output alu_result_i, rsp_ready_i,
        input  req_ready_o, alu_op1_o, alu_op2_o, alu_opsel_o,
        input  rsp_valid_o, rsp_result_o, rsp_tag_o, busy_cycles_o
    );
endinterface

// File: rtl/rv32_alu_share_arb.sv
// Round-robin sharing of one combinational rv32_int_alu between NUM_REQ
// requesters. One grant per cycle; the winner's operands drive the ALU and
// the ALU result is captured into that requester's depth-1 response slot.
// NUM_REQ/TAG_W must match the parameters of the connected interface.
module rv32_alu_share_arb #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input logic               clk,
    input logic               rst,
    rv32_alu_share_arb_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLL  = 4'd2,
        ALU_OP_SLT  = 4'd3,
        ALU_OP_SLTU = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_OR   = 4'd8,
        ALU_OP_AND  = 4'd9
    } int_alu_op_t;

    logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0][31:0]       rsp_result_q, rsp_result_d;
    logic [NUM_REQ-1:0][TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic [31:0]                    busy_q, busy_d;

    logic [NUM_REQ-1:0]             eligible;
    logic                           grant_vld;
    logic [PTR_W-1:0]               grant_idx;

    // Eligibility and rotating first-eligible search starting at rr_ptr.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned and no latch is inferred.
        idx       = 0;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        // A full slot that is being drained this cycle may be refilled.
        eligible  = bus.req_valid_i & (~rsp_valid_q | bus.rsp_ready_i);
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = PTR_W'(idx);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        // No handshakes while the block is held in reset.
        if (rst) begin
            grant_vld = 1'b0;
        end
    end

    // Grant outputs: one-hot ready and ALU operand mux, parked at 0/ADD when idle.
    always_comb begin
        bus.req_ready_o = '0;
        bus.alu_op1_o   = '0;
        bus.alu_op2_o   = '0;
        bus.alu_opsel_o = ALU_OP_ADD;
        if (grant_vld) begin
            bus.req_ready_o[grant_idx] = 1'b1;
            bus.alu_op1_o              = bus.req_op1_i[grant_idx];
            bus.alu_op2_o              = bus.req_op2_i[grant_idx];
            bus.alu_opsel_o            = bus.req_opsel_i[grant_idx];
        end
    end

    // Next state: pointer advance, response slot load/drain, saturating counter.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        busy_d       = busy_q;

        if (grant_vld) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            if (busy_q != '1) begin
                busy_d = busy_q + 32'd1;
            end
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && (grant_idx == PTR_W'(i))) begin
                rsp_valid_d[i]  = 1'b1;
                rsp_result_d[i] = bus.alu_result_i;
                rsp_tag_d[i]    = bus.req_tag_i[i];
            end else if (bus.rsp_ready_i[i]) begin
                // Result and tag are left as they were; only the valid drops.
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the response slots are plain flops, not a RAM, so they are
            // cleared by reset; results and tags must read 0 after reset.
            rr_ptr_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            busy_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its inputs regardless of statement order.
            rr_ptr_q     <= rr_ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_result_o  = rsp_result_q;
    assign bus.rsp_tag_o     = rsp_tag_q;
    assign bus.busy_cycles_o = busy_q;

endmodule

// File: tb/tb_rv32_alu_share_arb.sv
// Directed bench for rv32_alu_share_arb: a 2-requester instance driven from a
// per-cycle vector table plus hand-written sequences, and a 4-requester
// instance for the skip-full-slot case. A small ALU model feeds alu_result.
module tb_rv32_alu_share_arb;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    rv32_alu_share_arb_if #(.NUM_REQ(2), .TAG_W(4)) if2 ();
    rv32_alu_share_arb_if #(.NUM_REQ(4), .TAG_W(4)) if4 ();

    rv32_alu_share_arb #(.NUM_REQ(2), .TAG_W(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    rv32_alu_share_arb #(.NUM_REQ(4), .TAG_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference integer ALU standing in for rv32_int_alu.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] sel);
        case (sel)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb if2.alu_result_i = alu_model(if2.alu_op1_o, if2.alu_op2_o, if2.alu_opsel_o);
    always_comb if4.alu_result_i = alu_model(if4.alu_op1_o, if4.alu_op2_o, if4.alu_opsel_o);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One table row = one clock cycle of stimulus on the 2-requester instance
    // and the outputs expected during that cycle.
    typedef struct {
        bit          do_rst;
        logic [1:0]  rv;
        logic [1:0]  rr;
        logic [31:0] a0, b0;
        logic [3:0]  s0, t0;
        logic [31:0] a1, b1;
        logic [3:0]  s1, t1;
        logic [1:0]  e_ready;
        logic [31:0] e_alu;
        logic [1:0]  e_rv;
        logic [31:0] e_r0, e_r1;
        logic [3:0]  e_t0, e_t1;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit do_rst, input logic [1:0] rv, input logic [1:0] rr,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] s0, input logic [3:0] t0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] s1, input logic [3:0] t1,
                       input logic [1:0] e_ready, input logic [31:0] e_alu, input logic [1:0] e_rv,
                       input logic [31:0] e_r0, input logic [31:0] e_r1,
                       input logic [3:0] e_t0, input logic [3:0] e_t1, input logic [31:0] e_busy);
        vec_t v;
        v.do_rst = do_rst; v.rv = rv; v.rr = rr;
        v.a0 = a0; v.b0 = b0; v.s0 = s0; v.t0 = t0;
        v.a1 = a1; v.b1 = b1; v.s1 = s1; v.t1 = t1;
        v.e_ready = e_ready; v.e_alu = e_alu; v.e_rv = e_rv;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_t0 = e_t0; v.e_t1 = e_t1;
        v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        if2.req_valid_i = '0;
        if2.rsp_ready_i = '0;
        if2.req_op1_i   = '0;
        if2.req_op2_i   = '0;
        if2.req_opsel_i = '0;
        if2.req_tag_i   = '0;
        if4.req_valid_i = '0;
        if4.rsp_ready_i = '0;
        if4.req_op1_i   = '0;
        if4.req_op2_i   = '0;
        if4.req_opsel_i = '0;
        if4.req_tag_i   = '0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [3:0] exp_rdy4 [6];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        idle_inputs();

        // Reset state, with requests pending that must not be accepted.
        #1;
        rst = 1'b1;
        if2.req_valid_i = 2'b11;
        if2.req_op1_i[0] = 32'd9;
        if2.req_opsel_i[0] = OP_SUB;
        #2;
        check("reset req_ready", 64'(if2.req_ready_o), 64'h0);
        check("reset alu_op1", 64'(if2.alu_op1_o), 64'h0);
        check("reset alu_opsel", 64'(if2.alu_opsel_o), 64'(OP_ADD));
        check("reset rsp_valid", 64'(if2.rsp_valid_o), 64'h0);
        check("reset busy", 64'(if2.busy_cycles_o), 64'h0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single ADD 5+7 tag 3: accepted in cycle 0, response in cycle 1, drained by cycle 2.
        add(1, 2'b01, 2'b11, 5, 7, OP_ADD, 3,  0, 0, OP_ADD, 0,  2'b01, 5, 2'b00, 0,  0, 0, 0, 0);
        add(0, 2'b00, 2'b11, 5, 7, OP_ADD, 3,  0, 0, OP_ADD, 0,  2'b00, 0, 2'b01, 12, 0, 3, 0, 1);
        add(0, 2'b00, 2'b11, 5, 7, OP_ADD, 3,  0, 0, OP_ADD, 0,  2'b00, 0, 2'b00, 12, 0, 3, 0, 1);
        // Both requesters held valid: SUB 1-2 and SRA 0x80000000>>>4, grants alternate.
        add(1, 2'b11, 2'b11, 1, 2, OP_SUB, 1,  32'h8000_0000, 4, OP_SRA, 2,
            2'b01, 1, 2'b00, 0, 0, 0, 0, 0);
        add(0, 2'b11, 2'b11, 1, 2, OP_SUB, 1,  32'h8000_0000, 4, OP_SRA, 2,
            2'b10, 32'h8000_0000, 2'b01, 32'hFFFF_FFFF, 0, 1, 0, 1);
        add(0, 2'b11, 2'b11, 1, 2, OP_SUB, 1,  32'h8000_0000, 4, OP_SRA, 2,
            2'b01, 1, 2'b10, 32'hFFFF_FFFF, 32'hF800_0000, 1, 2, 2);
        add(0, 2'b11, 2'b11, 1, 2, OP_SUB, 1,  32'h8000_0000, 4, OP_SRA, 2,
            2'b10, 32'h8000_0000, 2'b01, 32'hFFFF_FFFF, 32'hF800_0000, 1, 2, 3);
        add(0, 2'b11, 2'b11, 1, 2, OP_SUB, 1,  32'h8000_0000, 4, OP_SRA, 2,
            2'b01, 1, 2'b10, 32'hFFFF_FFFF, 32'hF800_0000, 1, 2, 4);
        add(0, 2'b11, 2'b11, 1, 2, OP_SUB, 1,  32'h8000_0000, 4, OP_SRA, 2,
            2'b10, 32'h8000_0000, 2'b01, 32'hFFFF_FFFF, 32'hF800_0000, 1, 2, 5);
        add(0, 2'b00, 2'b11, 1, 2, OP_SUB, 1,  32'h8000_0000, 4, OP_SRA, 2,
            2'b00, 0, 2'b10, 32'hFFFF_FFFF, 32'hF800_0000, 1, 2, 6);
        // Requester 1 alone, SLTU 1<2 tag 5: drained and refilled every cycle.
        add(1, 2'b10, 2'b11, 0, 0, OP_ADD, 0,  1, 2, OP_SLTU, 5,  2'b10, 1, 2'b00, 0, 0, 0, 0, 0);
        add(0, 2'b10, 2'b11, 0, 0, OP_ADD, 0,  1, 2, OP_SLTU, 5,  2'b10, 1, 2'b10, 0, 1, 0, 5, 1);
        add(0, 2'b10, 2'b11, 0, 0, OP_ADD, 0,  1, 2, OP_SLTU, 5,  2'b10, 1, 2'b10, 0, 1, 0, 5, 2);
        add(0, 2'b10, 2'b11, 0, 0, OP_ADD, 0,  1, 2, OP_SLTU, 5,  2'b10, 1, 2'b10, 0, 1, 0, 5, 3);
        add(0, 2'b00, 2'b11, 0, 0, OP_ADD, 0,  1, 2, OP_SLTU, 5,  2'b00, 0, 2'b10, 0, 1, 0, 5, 4);

        for (int r = 0; r < vecs.size(); r++) begin
            if (vecs[r].do_rst) apply_reset();
            if2.req_valid_i    = vecs[r].rv;
            if2.rsp_ready_i    = vecs[r].rr;
            if2.req_op1_i[0]   = vecs[r].a0;
            if2.req_op2_i[0]   = vecs[r].b0;
            if2.req_opsel_i[0] = vecs[r].s0;
            if2.req_tag_i[0]   = vecs[r].t0;
            if2.req_op1_i[1]   = vecs[r].a1;
            if2.req_op2_i[1]   = vecs[r].b1;
            if2.req_opsel_i[1] = vecs[r].s1;
            if2.req_tag_i[1]   = vecs[r].t1;
            @(negedge clk);
            check($sformatf("row%0d req_ready", r), 64'(if2.req_ready_o), 64'(vecs[r].e_ready));
            check($sformatf("row%0d alu_op1", r), 64'(if2.alu_op1_o), 64'(vecs[r].e_alu));
            check($sformatf("row%0d rsp_valid", r), 64'(if2.rsp_valid_o), 64'(vecs[r].e_rv));
            check($sformatf("row%0d rsp_result0", r), 64'(if2.rsp_result_o[0]), 64'(vecs[r].e_r0));
            check($sformatf("row%0d rsp_result1", r), 64'(if2.rsp_result_o[1]), 64'(vecs[r].e_r1));
            check($sformatf("row%0d rsp_tag0", r), 64'(if2.rsp_tag_o[0]), 64'(vecs[r].e_t0));
            check($sformatf("row%0d rsp_tag1", r), 64'(if2.rsp_tag_o[1]), 64'(vecs[r].e_t1));
            check($sformatf("row%0d busy", r), 64'(if2.busy_cycles_o), 64'(vecs[r].e_busy));
            @(posedge clk);
            #1;
        end

        // Back-pressure: a held response blocks regrant until rsp_ready rises.
        apply_reset();
        if2.req_valid_i    = 2'b01;
        if2.rsp_ready_i    = 2'b00;
        if2.req_op1_i[0]   = 32'd10;
        if2.req_op2_i[0]   = 32'd20;
        if2.req_opsel_i[0] = OP_ADD;
        if2.req_tag_i[0]   = 4'd7;
        @(negedge clk);
        check("bp first grant", 64'(if2.req_ready_o), 64'h1);
        @(posedge clk);
        #1;
        if2.req_op1_i[0] = 32'd1;
        if2.req_op2_i[0] = 32'd1;
        if2.req_tag_i[0] = 4'd8;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d req_ready", k), 64'(if2.req_ready_o), 64'h0);
            check($sformatf("bp hold%0d rsp_valid0", k), 64'(if2.rsp_valid_o[0]), 64'h1);
            check($sformatf("bp hold%0d result", k), 64'(if2.rsp_result_o[0]), 64'd30);
            check($sformatf("bp hold%0d tag", k), 64'(if2.rsp_tag_o[0]), 64'd7);
            @(posedge clk);
            #1;
        end
        if2.rsp_ready_i = 2'b01;
        @(negedge clk);
        check("bp regrant same cycle", 64'(if2.req_ready_o), 64'h1);
        check("bp regrant alu_op1", 64'(if2.alu_op1_o), 64'd1);
        check("bp old result visible", 64'(if2.rsp_result_o[0]), 64'd30);
        @(posedge clk);
        #1;
        if2.req_valid_i = 2'b00;
        @(negedge clk);
        check("bp new rsp_valid0", 64'(if2.rsp_valid_o[0]), 64'h1);
        check("bp new result", 64'(if2.rsp_result_o[0]), 64'd2);
        check("bp new tag", 64'(if2.rsp_tag_o[0]), 64'd8);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp drained", 64'(if2.rsp_valid_o[0]), 64'h0);
        @(posedge clk);
        #1;

        // Asynchronous reset with both slots full and both requesters valid.
        apply_reset();
        if2.req_valid_i  = 2'b11;
        if2.rsp_ready_i  = 2'b00;
        if2.req_op1_i[0] = 32'd3;
        if2.req_op1_i[1] = 32'd4;
        @(negedge clk);
        check("ar grant0", 64'(if2.req_ready_o), 64'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ar grant1", 64'(if2.req_ready_o), 64'h2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ar both full", 64'(if2.rsp_valid_o), 64'h3);
        check("ar no grant", 64'(if2.req_ready_o), 64'h0);
        #2;
        rst = 1'b1;
        #1;
        check("ar rsp_valid cleared", 64'(if2.rsp_valid_o), 64'h0);
        check("ar result cleared", 64'(if2.rsp_result_o[1]), 64'h0);
        check("ar req_ready low", 64'(if2.req_ready_o), 64'h0);
        check("ar alu_op1 parked", 64'(if2.alu_op1_o), 64'h0);
        check("ar busy cleared", 64'(if2.busy_cycles_o), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ar first grant after release", 64'(if2.req_ready_o), 64'h1);
        check("ar alu_op1 after release", 64'(if2.alu_op1_o), 64'd3);
        @(posedge clk);
        #1;
        if2.req_valid_i = 2'b00;
        @(negedge clk);
        check("ar only new response", 64'(if2.rsp_valid_o), 64'h1);
        @(posedge clk);
        #1;

        // Four requesters, requester 2's slot kept full: it is skipped.
        apply_reset();
        if4.rsp_ready_i = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            if4.req_op1_i[i] = 32'(i + 100);
            if4.req_tag_i[i] = 4'(i);
        end
        if4.req_valid_i = 4'b0100;
        @(negedge clk);
        check("n4 fill slot2", 64'(if4.req_ready_o), 64'h4);
        @(posedge clk);
        #1;
        if4.req_valid_i = 4'b1000;
        @(negedge clk);
        check("n4 grant3", 64'(if4.req_ready_o), 64'h8);
        check("n4 slot2 full", 64'(if4.rsp_valid_o[2]), 64'h1);
        @(posedge clk);
        #1;
        exp_rdy4 = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        if4.req_valid_i = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("n4 cyc%0d req_ready", k), 64'(if4.req_ready_o), 64'(exp_rdy4[k]));
            check($sformatf("n4 cyc%0d slot2 held", k), 64'(if4.rsp_valid_o[2]), 64'h1);
            @(posedge clk);
            #1;
        end
        if4.req_valid_i = 4'b0000;
        @(negedge clk);
        check("n4 busy", 64'(if4.busy_cycles_o), 64'd8);
        check("n4 slot2 tag", 64'(if4.rsp_tag_o[2]), 64'd2);
        check("n4 slot2 result", 64'(if4.rsp_result_o[2]), 64'd102);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
